// File: rtl/clk_div_bank_pkg.sv
// Shared constants for the programmable clock-divider bank: board clock,
// default half-periods, output phase type and a frequency-to-half-period helper.
package genius_clk_pkg;

   localparam int unsigned CLK_HZ = 50_000_000;

   localparam int unsigned DEF_HALF_CH0 = 24_999_999;
   localparam int unsigned DEF_HALF_CH1 = 49_999_999;
   localparam int unsigned DEF_HALF_CH2 = 99_999_999;
   localparam int unsigned DEF_HALF_CH3 = 199_999_999;

   typedef enum logic {
      PH_LOW  = 1'b0,
      PH_HIGH = 1'b1
   } phase_t;

   // Terminal count giving a square wave of f_hz from CLK_HZ
   function automatic int unsigned hz_to_half(input int unsigned f_hz);
      return CLK_HZ / (2 * f_hz) - 1;
   endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Control/status bundle for clk_div_bank; the divider is the slave side.
// With CLK_DIV_DUTY_EN defined, duty_hi carries the high-phase terminal counts.
interface clk_div_bank_if #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned CNT_W = 28
);
   localparam int unsigned WR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [N_CH-1:0]       ch_en;
   logic                  restart;
   logic                  wr_en;
   logic [WR_W-1:0]       wr_ch;
   logic [CNT_W-1:0]      wr_half;
`ifdef CLK_DIV_DUTY_EN
   logic [N_CH*CNT_W-1:0] duty_hi;
`endif
   logic [N_CH-1:0]       clk_out;
   logic [N_CH-1:0]       tick;
   logic [N_CH-1:0]       pending;

   modport master (
      output ch_en, restart, wr_en, wr_ch, wr_half,
`ifdef CLK_DIV_DUTY_EN
             duty_hi,
`endif
      input  clk_out, tick, pending
   );

   modport slave (
      input  ch_en, restart, wr_en, wr_ch, wr_half,
`ifdef CLK_DIV_DUTY_EN
             duty_hi,
`endif
      output clk_out, tick, pending
   );

endinterface

// File: rtl/clk_div_bank_chan.sv
// One programmable divider channel: counter, active/shadow half-period,
// pending flag, square-wave output and rising-edge tick. CLK_DIV_DUTY_EN adds a high-phase count.
module clk_div_chan
   import genius_clk_pkg::*;
#(
   parameter int unsigned      CNT_W = 28,
   parameter logic [CNT_W-1:0] DEF   = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             restart,
   input  logic             wr_hit,
   input  logic [CNT_W-1:0] wr_half,
`ifdef CLK_DIV_DUTY_EN
   input  logic [CNT_W-1:0] duty_hi,
`endif
   output logic             clk_out,
   output logic             tick,
   output logic             pending
);

   phase_t           phase;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] active;
   logic [CNT_W-1:0] shadow;
   logic [CNT_W-1:0] term;
   logic             wrap;

`ifdef CLK_DIV_DUTY_EN
   logic [CNT_W-1:0] active_hi;
   assign term = (phase == PH_HIGH) ? active_hi : active;
`else
   assign term = active;
`endif

   // '>=' lets a counter already past a freshly lowered terminal wrap at once
   assign wrap    = (cnt >= term);
   assign clk_out = (phase == PH_HIGH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         phase     <= PH_LOW;
         tick      <= 1'b0;
         pending   <= 1'b0;
         active    <= DEF;
         shadow    <= DEF;
`ifdef CLK_DIV_DUTY_EN
         active_hi <= DEF;
`endif
      end else begin
         tick <= 1'b0;
         if (restart) begin
            cnt     <= '0;
            phase   <= PH_LOW;
            pending <= 1'b0;
            active  <= wr_hit ? wr_half : shadow;
            if (wr_hit)
               shadow <= wr_half;
`ifdef CLK_DIV_DUTY_EN
            active_hi <= duty_hi;
`endif
         end else begin
            if (wr_hit) begin
               shadow  <= wr_half;
               pending <= 1'b1;
            end
            if (en) begin
               if (wrap) begin
                  cnt    <= '0;
                  phase  <= (phase == PH_LOW) ? PH_HIGH : PH_LOW;
                  tick   <= (phase == PH_LOW);
                  // a write landing on the wrap cycle stays pending for the next wrap
                  active <= shadow;
                  if (!wr_hit)
                     pending <= 1'b0;
`ifdef CLK_DIV_DUTY_EN
                  active_hi <= duty_hi;
`endif
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH independent programmable clock dividers: write decode and restart fan-out.
// Optional feature macro: CLK_DIV_DUTY_EN (per-channel high-phase terminal count).
module clk_div_bank
   import genius_clk_pkg::*;
#(
   parameter int unsigned              N_CH     = 4,
   parameter int unsigned              CNT_W    = 28,
   parameter logic [N_CH*CNT_W-1:0]    DEF_HALF = {28'(DEF_HALF_CH3), 28'(DEF_HALF_CH2),
                                                   28'(DEF_HALF_CH1), 28'(DEF_HALF_CH0)}
) (
   input  logic          clk_50MHz,
   input  logic          reset,
   clk_div_bank_if.slave bus
);

   localparam int unsigned WR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [N_CH-1:0] wr_hit;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      // out-of-range channel numbers match no slice and are dropped
      assign wr_hit[i] = bus.wr_en && (bus.wr_ch == WR_W'(i));

      clk_div_chan #(
         .CNT_W (CNT_W),
         .DEF   (DEF_HALF[i*CNT_W +: CNT_W])
      ) u_chan (
         .clk     (clk_50MHz),
         .rst     (reset),
         .en      (bus.ch_en[i]),
         .restart (bus.restart),
         .wr_hit  (wr_hit[i]),
         .wr_half (bus.wr_half),
`ifdef CLK_DIV_DUTY_EN
         .duty_hi (bus.duty_hi[i*CNT_W +: CNT_W]),
`endif
         .clk_out (bus.clk_out[i]),
         .tick    (bus.tick[i]),
         .pending (bus.pending[i])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed self-checking bench for clk_div_bank (CNT_W=8) plus a 3-channel
// build for out-of-range write decode.
module tb_clk_div_bank;

   logic        clk = 1'b0;
   logic        rst;
   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   clk_div_bank_if #(.N_CH(4), .CNT_W(8)) bus ();
   clk_div_bank_if #(.N_CH(3), .CNT_W(8)) bus3 ();

   clk_div_bank #(
      .N_CH     (4),
      .CNT_W    (8),
      .DEF_HALF ({8'd7, 8'd3, 8'd1, 8'd0})
   ) dut (
      .clk_50MHz (clk),
      .reset     (rst),
      .bus       (bus.slave)
   );

   clk_div_bank #(
      .N_CH     (3),
      .CNT_W    (8),
      .DEF_HALF ({8'd2, 8'd1, 8'd0})
   ) dut3 (
      .clk_50MHz (clk),
      .reset     (rst),
      .bus       (bus3.slave)
   );

`ifdef CLK_DIV_DUTY_EN
   assign bus.duty_hi  = {8'd7, 8'd3, 8'd1, 8'd0};
   assign bus3.duty_hi = {8'd2, 8'd1, 8'd0};
`endif

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Square wave with half-period h cycles, phase origin at m=0 (low)
   function automatic logic sq(input int m, input int h);
      return ((m / h) % 2) == 1;
   endfunction

   function automatic logic rise(input int m, input int h);
      return sq(m, h) && ((m % h) == 0);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      bus.ch_en   = '1;  bus.restart  = 1'b0; bus.wr_en  = 1'b0;
      bus.wr_ch   = '0;  bus.wr_half  = '0;
      bus3.ch_en  = '1;  bus3.restart = 1'b0; bus3.wr_en = 1'b0;
      bus3.wr_ch  = '0;  bus3.wr_half = '0;
      step();
      step();
      chk("reset_clk", 32'(bus.clk_out), 32'h0);
      chk("reset_tick", 32'(bus.tick), 32'h0);
      chk("reset_pend", 32'(bus.pending), 32'h0);

      // defaults 0/1/3/7 give half-periods 1/2/4/8: outputs trace a binary count
      rst = 1'b0;
      for (int n = 1; n <= 32; n++) begin
         step();
         chk("pow2_clk", 32'(bus.clk_out), 32'(n) & 32'hF);
         chk("pow2_tick", 32'(bus.tick), 32'(n & ~(n - 1)) & 32'hF);
      end
      chk("pow2_pend", 32'(bus.pending), 32'h0);

      // ch1 half-period write mid-period: current half finishes, then 6-cycle halves
      bus.wr_en = 1'b1; bus.wr_ch = 2'd1; bus.wr_half = 8'd5;
      for (int n = 33; n <= 52; n++) begin
         step();
         bus.wr_en = 1'b0;
         chk("wr1_clk", 32'(bus.clk_out[1]),
             (n < 34) ? 32'h0 : 32'(((n - 34) / 6) % 2 == 0));
         chk("wr1_tick", 32'(bus.tick[1]), 32'(n == 34 || n == 46));
         chk("wr1_pend", 32'(bus.pending[1]), 32'(n == 33));
      end

      // restart with a simultaneous ch2 write of 9
      bus.restart = 1'b1; bus.wr_en = 1'b1; bus.wr_ch = 2'd2; bus.wr_half = 8'd9;
      step();
      bus.restart = 1'b0; bus.wr_en = 1'b0;
      chk("rs_clk", 32'(bus.clk_out), 32'h0);
      chk("rs_tick", 32'(bus.tick), 32'h0);
      chk("rs_pend", 32'(bus.pending), 32'h0);
      for (int m = 1; m <= 15; m++) begin
         step();
         chk("rs_run_clk", 32'(bus.clk_out),
             32'({sq(m, 8), sq(m, 10), sq(m, 6), sq(m, 1)}));
         chk("rs_run_tick", 32'(bus.tick),
             32'({rise(m, 8), rise(m, 10), rise(m, 6), rise(m, 1)}));
      end

      // ch2 disabled for 20 cycles while high with cnt=5
      bus.ch_en = 4'b1011;
      for (int m = 16; m <= 35; m++) begin
         step();
         chk("hold_clk2", 32'(bus.clk_out[2]), 32'h1);
         chk("hold_tick2", 32'(bus.tick[2]), 32'h0);
         chk("hold_clk0", 32'(bus.clk_out[0]), 32'(m % 2));
      end
      bus.ch_en = 4'hF;
      for (int m = 36; m <= 45; m++) begin
         step();
         chk("resume_clk2", 32'(bus.clk_out[2]), 32'(sq(m - 20, 10)));
         chk("resume_tick2", 32'(bus.tick[2]), 32'h0);
      end

      for (int m = 46; m <= 48; m++) begin
         step();
         chk("pre_wr3_clk", 32'(bus.clk_out[3]), 32'(sq(m, 8)));
      end

      // three back-to-back ch3 writes before its wrap: only the last (4) lands
      bus.wr_en = 1'b1; bus.wr_ch = 2'd3; bus.wr_half = 8'd0;
      for (int m = 49; m <= 66; m++) begin
         step();
         if (m == 49) bus.wr_half = 8'd2;
         if (m == 50) bus.wr_half = 8'd4;
         if (m == 51) bus.wr_en   = 1'b0;
         chk("wr3_clk", 32'(bus.clk_out[3]),
             (m < 56) ? 32'h0 : 32'(((m - 56) / 5) % 2 == 0));
         chk("wr3_tick", 32'(bus.tick[3]), 32'(m == 56 || m == 66));
         chk("wr3_pend", 32'(bus.pending[3]), 32'(m < 56));
      end

      // reset mid-period with a pending write
      bus.wr_en = 1'b1; bus.wr_ch = 2'd1; bus.wr_half = 8'd2;
      step();
      bus.wr_en = 1'b0;
      chk("prerst_pend", 32'(bus.pending), 32'h2);
      #3;
      rst = 1'b1;
      #1;
      chk("async_clk", 32'(bus.clk_out), 32'h0);
      chk("async_tick", 32'(bus.tick), 32'h0);
      chk("async_pend", 32'(bus.pending), 32'h0);
      step();
      step();
      chk("held_clk", 32'(bus.clk_out), 32'h0);

      // release: defaults restored; 3-channel build sees only wr_ch=3 writes
      bus3.wr_en = 1'b1; bus3.wr_ch = 2'd3; bus3.wr_half = 8'd0;
      rst = 1'b0;
      for (int n = 1; n <= 16; n++) begin
         step();
         chk("post_clk", 32'(bus.clk_out), 32'(n) & 32'hF);
         chk("post_pend", 32'(bus.pending), 32'h0);
         chk("oor_clk", 32'(bus3.clk_out), 32'({sq(n, 3), sq(n, 2), sq(n, 1)}));
         chk("oor_pend", 32'(bus3.pending), 32'h0);
      end
      bus3.wr_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
